// File: rtl/memory_loader.sv
// Byte-stream program loader: parses a framed image (sync, count, big-endian words,
// checksum), writes each word into program RAM and holds the CPU until the image verifies.
module memory_loader #(
    parameter int         ADDR_WIDTH = 13,
    parameter int         DATA_WIDTH = 16,
    parameter int         DEPTH      = 32,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_value,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HIGH,
        S_LOW,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // Count byte is 8 bits, so a 9-bit limit keeps the range check exact for any DEPTH.
    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

    state_t                 state_q, state_d;
    logic [7:0]             count_q, count_d;
    logic [7:0]             high_q, high_d;
    logic [7:0]             word_cnt_q, word_cnt_d;
    logic [7:0]             sum_q, sum_d;
    logic                   byte_ready_q, byte_ready_d;
    logic                   write_enable_q, write_enable_d;
    logic [ADDR_WIDTH-1:0]  write_address_q, write_address_d;
    logic [DATA_WIDTH-1:0]  write_value_q, write_value_d;
    logic                   cpu_hold_q, cpu_hold_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   xfer;

    assign xfer = byte_valid && byte_ready_q;

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        high_d          = high_q;
        word_cnt_d      = word_cnt_q;
        sum_d           = sum_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_value_d   = write_value_q;
        cpu_hold_d      = cpu_hold_q;
        done_d          = done_q;
        error_d         = error_q;

        case (state_q)
            // Idle and both terminal states resynchronise on the marker and drop anything else.
            S_IDLE, S_DONE, S_ERROR: begin
                if (xfer && byte_data == SYNC_BYTE) begin
                    state_d    = S_COUNT;
                    sum_d      = 8'd0;
                    word_cnt_d = 8'd0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    count_d = byte_data;
                    if (byte_data == 8'd0 || {1'b0, byte_data} > DEPTH_LIM) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_HIGH;
                    end
                end
            end
            S_HIGH: begin
                if (xfer) begin
                    high_d  = byte_data;
                    sum_d   = sum_q + byte_data;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (xfer) begin
                    sum_d           = sum_q + byte_data;
                    write_enable_d  = 1'b1;
                    write_address_d = ADDR_WIDTH'(word_cnt_q);
                    write_value_d   = DATA_WIDTH'({high_q, byte_data});
                    state_d         = S_WRITE;
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + 8'd1;
                state_d    = (word_cnt_q + 8'd1 == count_q) ? S_CHECK : S_HIGH;
            end
            S_CHECK: begin
                if (xfer) begin
                    if (byte_data == sum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered ready: low exactly for the cycle spent in WRITE.
        byte_ready_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            count_q         <= 8'd0;
            high_q          <= 8'd0;
            word_cnt_q      <= 8'd0;
            sum_q           <= 8'd0;
            byte_ready_q    <= 1'b1;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_value_q   <= '0;
            cpu_hold_q      <= 1'b1;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            high_q          <= high_d;
            word_cnt_q      <= word_cnt_d;
            sum_q           <= sum_d;
            byte_ready_q    <= byte_ready_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_value_q   <= write_value_d;
            cpu_hold_q      <= cpu_hold_d;
            done_q          <= done_d;
            error_q         <= error_d;
        end
    end

    assign byte_ready    = byte_ready_q;
    assign write_enable  = write_enable_q;
    assign write_address = write_address_q;
    assign write_value   = write_value_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_memory_loader.sv
// Scenario bench for memory_loader: directed frames plus randomized frames checked
// against expectations built directly from the frame contents.
module tb_memory_loader;
    localparam int AW    = 13;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_ready;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [15:0]   write_value;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    memory_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(16), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)
    ) dut (
        .clock(clock), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .write_enable(write_enable), .write_address(write_address),
        .write_value(write_value), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    // Write monitor: records every RAM write and counts ready-low cycles
    int          mon_addr[$];
    logic [15:0] mon_val[$];
    int          mon_rdy_low = 0;
    int          mon_we_multi = 0;
    bit          we_prev = 1'b0;

    always @(negedge clock) begin
        if (write_enable) begin
            mon_addr.push_back(int'(write_address));
            mon_val.push_back(write_value);
            if (we_prev) mon_we_multi++;
        end
        we_prev = write_enable;
        if (!byte_ready) mon_rdy_low++;
    end

    task automatic clear_mon();
        mon_addr.delete();
        mon_val.delete();
        mon_rdy_low = 0;
        mon_we_multi = 0;
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    // Called just after a rising edge; returns just after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clock);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 16 && !acc; i++) begin
            @(negedge clock);
            if (byte_ready) begin
                @(posedge clock);
                #1;
                acc = 1'b1;
            end
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte %02h not accepted within 16 cycles", b);
        end
    endtask

    task automatic drive_frame(input logic [7:0] fb[$], input int mode);
        clear_mon();
        foreach (fb[i]) send_byte(fb[i], pick_gap(mode));
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [33:0] exp_v, got_v;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        exp_v = {1'b1, 1'b0, 13'd0, 16'd0, 1'b1, 1'b0, 1'b0};
        got_v = {byte_ready, write_enable, write_address, write_value, cpu_hold, done, error};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL reset_values: got %h required %h", got_v, exp_v);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_good_frame();
        logic [7:0]  fb[$];
        logic [15:0] ev[$];
        fb = {8'hA5, 8'h02, 8'h80, 8'h01, 8'h60, 8'h40};
        ev = {16'h8001, 16'h6040};
        drive_frame(fb, 0);
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL good_pre_check: hold=%b done=%b required hold=1 done=0", cpu_hold, done);
        end
        send_byte(8'h21, 0);
        byte_valid = 1'b0;
        checks++;
        if (mon_addr.size() !== 2) begin
            failures++;
            $display("FAIL good_write_count: got %0d required 2", mon_addr.size());
        end
        for (int i = 0; i < mon_addr.size() && i < 2; i++) begin
            checks++;
            if (mon_addr[i] !== i || mon_val[i] !== ev[i]) begin
                failures++;
                $display("FAIL good_write%0d: got (%0d,%h) required (%0d,%h)", i, mon_addr[i], mon_val[i], i, ev[i]);
            end
        end
        checks++;
        if (mon_we_multi !== 0 || mon_rdy_low !== 2) begin
            failures++;
            $display("FAIL good_strobes: we_multi=%0d ready_low=%0d required 0 and 2", mon_we_multi, mon_rdy_low);
        end
        checks++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            failures++;
            $display("FAIL good_result: done/err/hold=%b required 100", {done, error, cpu_hold});
        end
    endtask

    task automatic test_reload();
        logic [7:0] fb[$];
        send_byte(8'hA5, 0);
        byte_valid = 1'b0;
        checks++;
        if ({done, error, cpu_hold} !== 3'b001) begin
            failures++;
            $display("FAIL reload_sync: done/err/hold=%b required 001", {done, error, cpu_hold});
        end
        fb = {8'h01, 8'hAB, 8'hCD, 8'h78};
        drive_frame(fb, 0);
        checks++;
        if (mon_addr.size() !== 1 || mon_addr[0] !== 0 || mon_val[0] !== 16'hABCD) begin
            failures++;
            $display("FAIL reload_write: got %0d writes first (%0d,%h) required 1 write (0,abcd)",
                     mon_addr.size(), (mon_addr.size() > 0) ? mon_addr[0] : -1,
                     (mon_val.size() > 0) ? mon_val[0] : 16'hxxxx);
        end
        checks++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            failures++;
            $display("FAIL reload_result: done/err/hold=%b required 100", {done, error, cpu_hold});
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] fb[$];
        fb = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h00};
        drive_frame(fb, 0);
        checks++;
        if (mon_addr.size() !== 1 || mon_addr[0] !== 0 || mon_val[0] !== 16'h1234) begin
            failures++;
            $display("FAIL badsum_write: got %0d writes first (%0d,%h) required 1 write (0,1234)",
                     mon_addr.size(), (mon_addr.size() > 0) ? mon_addr[0] : -1,
                     (mon_val.size() > 0) ? mon_val[0] : 16'hxxxx);
        end
        checks++;
        if ({done, error, cpu_hold} !== 3'b011) begin
            failures++;
            $display("FAIL badsum_result: done/err/hold=%b required 011", {done, error, cpu_hold});
        end
    endtask

    task automatic test_bad_count();
        logic [7:0] fb[$];
        logic [7:0] bad_n[2];
        bad_n[0] = 8'h00;
        bad_n[1] = 8'h21;
        for (int k = 0; k < 2; k++) begin
            fb = {8'hA5, bad_n[k]};
            drive_frame(fb, 0);
            repeat (2) @(posedge clock);
            #1;
            checks++;
            if (mon_addr.size() !== 0 || {done, error, cpu_hold} !== 3'b011) begin
                failures++;
                $display("FAIL badcount_%02h: writes=%0d done/err/hold=%b required 0 writes 011",
                         bad_n[k], mon_addr.size(), {done, error, cpu_hold});
            end
        end
        fb = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};
        drive_frame(fb, 0);
        checks++;
        if (mon_addr.size() !== 1 || mon_val[0] !== 16'h0000 || {done, error, cpu_hold} !== 3'b100) begin
            failures++;
            $display("FAIL badcount_recover: writes=%0d done/err/hold=%b required 1 write 100",
                     mon_addr.size(), {done, error, cpu_hold});
        end
    endtask

    task automatic test_noise_stalls();
        logic [7:0]  fb[$];
        logic [15:0] ev[$];
        fb = {8'h3C, 8'hFF, 8'hA5, 8'h02, 8'h80, 8'h01, 8'h60, 8'h40, 8'h21};
        ev = {16'h8001, 16'h6040};
        drive_frame(fb, 1);
        checks++;
        if (mon_addr.size() !== 2) begin
            failures++;
            $display("FAIL stall_write_count: got %0d required 2", mon_addr.size());
        end
        for (int i = 0; i < mon_addr.size() && i < 2; i++) begin
            checks++;
            if (mon_addr[i] !== i || mon_val[i] !== ev[i]) begin
                failures++;
                $display("FAIL stall_write%0d: got (%0d,%h) required (%0d,%h)", i, mon_addr[i], mon_val[i], i, ev[i]);
            end
        end
        checks++;
        if ({done, error, cpu_hold} !== 3'b100 || mon_rdy_low !== 2) begin
            failures++;
            $display("FAIL stall_result: done/err/hold=%b ready_low=%0d required 100 and 2",
                     {done, error, cpu_hold}, mon_rdy_low);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  fb[$];
        logic [33:0] exp_v, got_v;
        fb = {8'hA5, 8'h02, 8'h80};
        drive_frame(fb, 0);
        reset_n = 1'b0;
        #2;
        exp_v = {1'b1, 1'b0, 13'd0, 16'd0, 1'b1, 1'b0, 1'b0};
        got_v = {byte_ready, write_enable, write_address, write_value, cpu_hold, done, error};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL midreset_values: got %h required %h", got_v, exp_v);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        fb = {8'hA5, 8'h02, 8'h80, 8'h01, 8'h60, 8'h40, 8'h21};
        drive_frame(fb, 0);
        checks++;
        if (mon_addr.size() !== 2 || mon_addr[0] !== 0 || mon_addr[1] !== 1 ||
            mon_val[0] !== 16'h8001 || mon_val[1] !== 16'h6040 || done !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reload: writes=%0d done=%b required 2 writes from address 0 and done=1",
                     mon_addr.size(), done);
        end
    endtask

    task automatic test_random();
        logic [7:0]  fb[$];
        logic [15:0] ev[$];
        logic [7:0]  h, l, nz, sum;
        int          n;
        bit          bad_cnt, bad_sum, exp_done;
        for (int f = 0; f < 30; f++) begin
            fb.delete();
            ev.delete();
            for (int k = int'($urandom_range(0, 2)); k > 0; k--) begin
                nz = 8'($urandom_range(0, 255));
                if (nz == 8'hA5) nz = 8'h5A;
                fb.push_back(nz);
            end
            bad_cnt = ($urandom_range(0, 7) == 0);
            if (bad_cnt) n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(DEPTH + 1, 255));
            else n = int'($urandom_range(1, DEPTH));
            fb.push_back(8'hA5);
            fb.push_back(8'(n));
            sum = 8'd0;
            bad_sum = 1'b0;
            if (!bad_cnt) begin
                for (int i = 0; i < n; i++) begin
                    h = 8'($urandom_range(0, 255));
                    l = 8'($urandom_range(0, 255));
                    fb.push_back(h);
                    fb.push_back(l);
                    ev.push_back({h, l});
                    sum = sum + h + l;
                end
                bad_sum = ($urandom_range(0, 2) == 0);
                fb.push_back(bad_sum ? sum + 8'($urandom_range(1, 255)) : sum);
            end
            exp_done = !bad_cnt && !bad_sum;
            drive_frame(fb, 2);
            repeat (2) @(posedge clock);
            #1;
            checks++;
            if (mon_addr.size() !== ev.size() || mon_rdy_low !== ev.size() || mon_we_multi !== 0) begin
                failures++;
                $display("FAIL rand%0d_writes: writes=%0d ready_low=%0d we_multi=%0d required %0d %0d 0",
                         f, mon_addr.size(), mon_rdy_low, mon_we_multi, ev.size(), ev.size());
            end
            for (int i = 0; i < mon_addr.size() && i < ev.size(); i++) begin
                checks++;
                if (mon_addr[i] !== i || mon_val[i] !== ev[i]) begin
                    failures++;
                    $display("FAIL rand%0d_word%0d: got (%0d,%h) required (%0d,%h)",
                             f, i, mon_addr[i], mon_val[i], i, ev[i]);
                end
            end
            checks++;
            if ({done, error, cpu_hold} !== {exp_done, !exp_done, !exp_done}) begin
                failures++;
                $display("FAIL rand%0d_result: done/err/hold=%b required %b",
                         f, {done, error, cpu_hold}, {exp_done, !exp_done, !exp_done});
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_reload();
        test_bad_checksum();
        test_bad_count();
        test_noise_stalls();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_loader.md
# memory_loader

Write-side companion to the CPU's program memory. Accepts a byte stream over a valid/ready handshake, checks a framed program image, assembles big-endian 16-bit instruction words, and issues one synchronous write per word into the program RAM starting at address 0. Holds the CPU in reset until a complete, checksum-verified image has been written.

## Interface

Parameters:
- `ADDR_WIDTH`, 13, width of `write_address` (matches the RAM read address).
- `DATA_WIDTH`, 16, instruction word width; fixed at 16, two bytes per word.
- `DEPTH`, 32, number of RAM words; the maximum word count per frame.
- `SYNC_BYTE`, 8'hA5, frame start marker.

Ports:
- `clock`, input, 1, single system clock; all logic on the rising edge.
- `reset_n`, input, 1, asynchronous, active-low reset.
- `byte_valid`, input, 1, source presents `byte_data`.
- `byte_data`, input, 8, incoming stream byte.
- `byte_ready`, output, 1, loader can accept a byte this cycle.
- `write_enable`, output, 1, single-cycle RAM write strobe.
- `write_address`, output, ADDR_WIDTH, RAM word address.
- `write_value`, output, 16, RAM write data.
- `cpu_hold`, output, 1, keeps the CPU in reset while high.
- `done`, output, 1, last frame loaded and verified.
- `error`, output, 1, last frame rejected.

## Operation

- **Frame format:** `SYNC_BYTE`, count N (1..DEPTH), N×(high byte, low byte), checksum. The checksum is the sum modulo 256 of the 2N data bytes only; the sync and count bytes are excluded.
- **Transfer rule:** a byte transfers on a rising edge where `byte_valid && byte_ready`.
- **States:**
  - IDLE: accept and discard bytes; on `SYNC_BYTE` go to COUNT.
  - COUNT: latch N. If N is 0 or N > DEPTH, go to ERROR; otherwise go to HIGH.
  - HIGH: latch the high byte; go to LOW.
  - LOW: latch the low byte; go to WRITE.
  - WRITE: one cycle, `byte_ready`=0, `write_enable`=1. Increment the word counter, then go to HIGH, or to CHECK once N words have been written.
  - CHECK: compare the received byte with the running sum. A match goes to DONE; a mismatch goes to ERROR.
  - DONE: `done`=1, `cpu_hold`=0.
  - ERROR: `error`=1, `cpu_hold`=1.
- **Restart:** in DONE or ERROR, bytes are accepted. A `SYNC_BYTE` clears `done`/`error`, sets `cpu_hold`=1, and goes to COUNT. Any other byte is ignored.
- **Addressing:** `write_address` = word index (0..N-1), zero-extended to ADDR_WIDTH. It never wraps because N ≤ DEPTH.
- **Data assembly:** `write_value` = {high byte, low byte}.
- **Checksum width:** the running sum is 8 bits, wraps modulo 256, and clears on each sync.
- **Partial writes:** words written before an ERROR stay in RAM; the CPU remains held.

## Timing

- **Reset values:** state IDLE, `byte_ready`=1, `write_enable`=0, `write_address`=0, `write_value`=0, `cpu_hold`=1, `done`=0, `error`=0, word counter 0, sum 0.
- **Reset mid-frame:** the frame is abandoned immediately, with the same values as reset.
- **`byte_ready`:** 1 in every state except WRITE, and registered. The source must hold `byte_valid`/`byte_data` until the transfer completes.
- **Write latency:** low byte accepted at edge k. `write_enable`, `write_address` and `write_value` are valid during cycle k to k+1, and the RAM captures them at edge k+1. `write_enable` is low in all other cycles.
- **Sustained rate:** one word per 3 cycles at best (HIGH, LOW, WRITE).
- **DONE/ERROR timing:** the checksum byte is accepted at edge c. `done`/`error` rise and `cpu_hold` falls (on a match) at edge c, as registered outputs visible in cycle c to c+1.
- **Stalls:** `byte_valid` low in any state causes no state change.

## Test plan

- **Good frame:** A5 02 80 01 60 40 21, `byte_valid` held high. Required: writes (0, 0x8001) and (1, 0x6040), each `write_enable` a single cycle; `byte_ready` low in exactly those 2 cycles; `done`=1, `error`=0, `cpu_hold` falls after the 0x21 byte.
- **Bad checksum:** A5 01 12 34 00. Required: one write (0, 0x1234); then `error`=1, `done`=0, `cpu_hold` stays 1.
- **Bad count:** A5 00, and separately A5 21 with DEPTH=32. Required: ERROR immediately with no writes. Then A5 01 00 00 00 gives `done`=1 and `error`=0.
- **Noise and stalls:** 3C FF, then a good frame with `byte_valid` toggling every cycle. Required: the noise bytes are ignored and the same writes and result occur as with an unstalled stream.
- **Reset mid-frame:** `reset_n` low after A5 02 80. Required: all outputs at reset values. A following good frame writes starting at address 0.
- **Reload after DONE:** second frame A5 01 AB CD 78. Required: `cpu_hold` rises on the A5, the write is (0, 0xABCD), and `done` is reasserted.
